cam_request_controller: RTL and testbench
=========================================

// Module: cam_request_controller
// PURPOSE
//  Sequences a CAM_Array-style content-addressable memory between a single requester and the array.
//  Accepts search / write / invalidate requests over a valid-ready port and allocates free rows.
//  Drives one-hot row write enables, search word and don't-care mask into the array.
//  Returns the lowest-index valid match, or the allocated row, over a valid-ready response port.
// PARAMETERS
//  CAM_DEPTH  8  number of CAM rows (power of 2, >=2)
//  CAM_WIDTH  8  bits per CAM word
//  IDX_W      3  row index width, = $clog2(CAM_DEPTH)
//  MATCH_LAT  1  cycles from cam_search_word/cam_dont_care_mask driven to cam_match valid (>=1)
// PORTS
//  clk                 in   1          single clock, rising edge
//  rst                 in   1          synchronous reset, active-high
//  req_valid           in   1          request present
//  req_ready           out  1          controller can accept request
//  req_op              in   2          00 search, 01 write, 10 invalidate, 11 reserved
//  req_word            in   CAM_WIDTH  search key / word to store
//  req_mask            in   CAM_WIDTH  search don't-care bits (1 = ignore); unused for write
//  req_index           in   IDX_W      row to invalidate
//  rsp_valid           out  1          response present
//  rsp_ready           in   1          requester accepts response
//  rsp_hit             out  1          search matched a valid row
//  rsp_index           out  IDX_W      matched / written row
//  rsp_err             out  1          request failed
//  cam_we              out  CAM_DEPTH  one-hot row write enable to array
//  cam_search_word     out  CAM_WIDTH  word to array (search key or write data)
//  cam_dont_care_mask  out  CAM_WIDTH  mask to array
//  cam_match           in   CAM_DEPTH  decoded match vector from array
//  full                out  1          all rows valid
//  count               out  IDX_W+1    number of valid rows
// BEHAVIOUR
//  - Reset: state IDLE; valid bitmap cleared; all outputs 0 (req_ready 0 during rst, 1 the cycle after).
//    rst mid-operation aborts the in-flight op; no response is produced.
//  - FSM: IDLE -> EXEC -> WAIT -> RESP -> IDLE.
//    - req_ready = 1 only in IDLE; accept on req_valid & req_ready.
//    - Request fields are registered at accept.
//  - EXEC, write, free row exists: cam_we one-hot on lowest-index free row for exactly 1 cycle.
//    cam_search_word = req_word, cam_dont_care_mask = 0; valid bit set at the same edge.
//    Skip WAIT; RESP with rsp_index = row, rsp_err = 0.
//  - Write when full: no cam_we pulse; rsp_err = 1, rsp_index = 0.
//  - Search: EXEC drives key and mask (held through WAIT); WAIT lasts MATCH_LAT cycles.
//    On the last WAIT cycle, sample v = cam_match & valid_bitmap.
//    rsp_hit = |v; rsp_index = lowest set bit of v (0 if none); rsp_err = 0.
//  - Invalidate: no array access. rsp_index = req_index.
//    Row valid: clear the valid bit, rsp_err = 0. Row already invalid: rsp_err = 1.
//  - Reserved op: no action; RESP with rsp_err = 1.
//  - RESP: rsp_valid held with stable fields until rsp_ready; handshake cycle -> IDLE.
//  - cam_we is 0 in every state except EXEC-write.
//  - Outputs are all registered. Search latency accept -> rsp_valid = MATCH_LAT + 2 cycles.
//  - count/full update the cycle after the valid bitmap changes.
//  - Back-to-back: the next req can be accepted 1 cycle after the rsp handshake.
// CONFIGURATION
//  CAM_CTRL_REPLACE_EN defined: write when full overwrites the row at a round-robin victim pointer.
//    rsp_err = 0, rsp_index = victim; pointer increments, DEPTH-1 wraps to 0; pointer resets to 0.
//  Undefined: write when full is rejected with rsp_err = 1; no victim pointer logic exists.
// TESTING
//  1. Reset, 3 writes 0xA1,0xB2,0xC3 -> rsp_index 0,1,2 err 0; one-cycle cam_we 0x01,0x02,0x04; count 3.
//  2. Search 0xB2 mask 0, model returns cam_match=0x02 after MATCH_LAT -> hit 1, index 1 at accept+MATCH_LAT+2.
//  3. cam_match=0x06 with row 1 invalidated first -> hit 1, index 2; invalidate row 1 again -> err 1.
//  4. Fill 8 rows, 9th write -> err 1, no cam_we (REPLACE_EN: index 0, then 1 on 10th write).
//  5. Hold rsp_ready low 5 cycles -> rsp fields stable, req_ready 0; assert rst in WAIT -> no rsp, count 0.
//  6. Search with cam_match=0 -> hit 0, index 0; op 11 -> err 1, no cam_we.

Source files
------------

// File: rtl/cam_request_controller.sv
// rtl/cam_request_controller.sv - request sequencer for a CAM_Array-style content-addressable memory
//
// Purpose
//   Accepts search / write / invalidate requests from one requester over a
//   valid-ready port. Writes are placed in the lowest-index free row. The
//   controller drives the search word, the don't-care mask and one-hot row
//   write enables into the array, and returns the lowest-index valid match
//   or the allocated row over a valid-ready response port.
//   Request flow: IDLE -> EXEC -> (WAIT, searches only) -> RESP -> IDLE.
//
// Configuration
//   CAM_CTRL_REPLACE_EN  defined: a write to a full array overwrites the row
//                        selected by a round-robin victim pointer.
//                        undefined: a write to a full array is rejected
//                        with rsp_err = 1.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_*               request channel (op 00 search, 01 write,
//                       10 invalidate, 11 reserved)
//   rsp_*               response channel (hit, index, err)
//   cam_we              one-hot row write enable to the array
//   cam_search_word     search key or write data to the array
//   cam_dont_care_mask  search don't-care bits to the array (1 = ignore)
//   cam_match           match vector from the array, MATCH_LAT cycles
//                       after word/mask are driven
//   full, count         occupancy of the valid bitmap
module cam_request_controller #(
  parameter int CAM_DEPTH = 8,
  parameter int CAM_WIDTH = 8,
  parameter int IDX_W     = $clog2(CAM_DEPTH),
  parameter int MATCH_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [CAM_WIDTH-1:0] req_word,
  input  logic [CAM_WIDTH-1:0] req_mask,
  input  logic [IDX_W-1:0]     req_index,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [IDX_W-1:0]     rsp_index,
  output logic                 rsp_err,
  output logic [CAM_DEPTH-1:0] cam_we,
  output logic [CAM_WIDTH-1:0] cam_search_word,
  output logic [CAM_WIDTH-1:0] cam_dont_care_mask,
  input  logic [CAM_DEPTH-1:0] cam_match,
  output logic                 full,
  output logic [IDX_W:0]       count
);

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam int         WAIT_W    = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam logic [CAM_DEPTH-1:0] ROW0 = {{(CAM_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CAM_DEPTH-1:0]  valid_q, valid_d;
  logic [1:0]            op_q, op_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [IDX_W-1:0]      alloc_q, alloc_d;
  logic                  werr_q, werr_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  req_ready_d, rsp_valid_d, rsp_hit_d, rsp_err_d;
  logic [IDX_W-1:0]      rsp_index_d;
  logic [CAM_DEPTH-1:0]  cam_we_d;
  logic [CAM_WIDTH-1:0]  word_d, mask_d;
  logic [CAM_DEPTH-1:0]  match_v;
  logic [IDX_W-1:0]      free_idx;
  logic                  accept, wait_last;
`ifdef CAM_CTRL_REPLACE_EN
  logic [IDX_W-1:0]      victim_q, victim_d;
`endif

  // Lowest set bit; the downward scan lets the lowest index win.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [CAM_DEPTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [CAM_DEPTH-1:0] v);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      n = n + {{IDX_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  assign accept    = req_valid & req_ready;
  assign match_v   = cam_match & valid_q;
  assign free_idx  = lowest_set(~valid_q);
  assign wait_last = (wait_cnt_q == WAIT_W'(MATCH_LAT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = (op_q == OP_SEARCH) ? WAIT : RESP;
      WAIT:    if (wait_last) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for every registered output and the bitmap.
  always_comb begin
    valid_d     = valid_q;
    op_d        = op_q;
    index_d     = index_q;
    alloc_d     = alloc_q;
    werr_d      = werr_q;
    wait_cnt_d  = wait_cnt_q;
    cam_we_d    = '0;
    word_d      = cam_search_word;
    mask_d      = cam_dont_care_mask;
    rsp_valid_d = rsp_valid;
    rsp_hit_d   = rsp_hit;
    rsp_index_d = rsp_index;
    rsp_err_d   = rsp_err;
    req_ready_d = (state_d == IDLE);
`ifdef CAM_CTRL_REPLACE_EN
    victim_d    = victim_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = req_op;
          index_d = req_index;
          alloc_d = '0;
          werr_d  = 1'b0;
          if (req_op == OP_SEARCH) begin
            word_d = req_word;
            mask_d = req_mask;
          end else if (req_op == OP_WRITE) begin
            word_d = req_word;
            mask_d = '0;
            // The write pulse is registered here so it is high exactly
            // during EXEC; the row is marked valid on the same edge.
            if (!(&valid_q)) begin
              cam_we_d          = ROW0 << free_idx;
              valid_d[free_idx] = 1'b1;
              alloc_d           = free_idx;
            end else begin
`ifdef CAM_CTRL_REPLACE_EN
              cam_we_d = ROW0 << victim_q;
              alloc_d  = victim_q;
              victim_d = victim_q + 1'b1;  // DEPTH is a power of 2: wraps to 0
`else
              werr_d   = 1'b1;
`endif
            end
          end
        end
      end
      EXEC: begin
        wait_cnt_d = '0;
        rsp_hit_d  = 1'b0;
        case (op_q)
          OP_SEARCH: ;
          OP_WRITE: begin
            rsp_index_d = alloc_q;
            rsp_err_d   = werr_q;
          end
          OP_INVAL: begin
            rsp_index_d      = index_q;
            rsp_err_d        = ~valid_q[index_q];
            valid_d[index_q] = 1'b0;
          end
          default: begin
            rsp_index_d = '0;
            rsp_err_d   = 1'b1;
          end
        endcase
        if (op_q != OP_SEARCH) rsp_valid_d = 1'b1;
      end
      WAIT: begin
        if (wait_last) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = |match_v;
          rsp_index_d = lowest_set(match_v);
          rsp_err_d   = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_hit_d   = 1'b0;
          rsp_index_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q            <= '0;
      op_q               <= '0;
      index_q            <= '0;
      alloc_q            <= '0;
      werr_q             <= 1'b0;
      wait_cnt_q         <= '0;
      req_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_hit            <= 1'b0;
      rsp_index          <= '0;
      rsp_err            <= 1'b0;
      cam_we             <= '0;
      cam_search_word    <= '0;
      cam_dont_care_mask <= '0;
      count              <= '0;
      full               <= 1'b0;
`ifdef CAM_CTRL_REPLACE_EN
      victim_q           <= '0;
`endif
    end else begin
      valid_q            <= valid_d;
      op_q               <= op_d;
      index_q            <= index_d;
      alloc_q            <= alloc_d;
      werr_q             <= werr_d;
      wait_cnt_q         <= wait_cnt_d;
      req_ready          <= req_ready_d;
      rsp_valid          <= rsp_valid_d;
      rsp_hit            <= rsp_hit_d;
      rsp_index          <= rsp_index_d;
      rsp_err            <= rsp_err_d;
      cam_we             <= cam_we_d;
      cam_search_word    <= word_d;
      cam_dont_care_mask <= mask_d;
      // Occupancy follows the bitmap one cycle later.
      count              <= popcount(valid_q);
      full               <= &valid_q;
`ifdef CAM_CTRL_REPLACE_EN
      victim_q           <= victim_d;
`endif
    end
  end

endmodule

// File: tb/tb_cam_request_controller.sv
// tb/tb_cam_request_controller.sv - self-checking bench for cam_request_controller
module tb_cam_request_controller;

  localparam int MATCH_LAT = 1;
  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef struct packed {
    logic       hit;
    logic [2:0] index;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_word, req_mask;
  logic [2:0] req_index;
  logic       rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [2:0] rsp_index;
  logic [7:0] cam_we, cam_search_word, cam_dont_care_mask, cam_match;
  logic       full;
  logic [3:0] count;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  rsp_t exp_q[$];

  // CAM array model
  logic [7:0] mem [8];
  logic [7:0] raw_match;
  logic [7:0] mpipe [MATCH_LAT];
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  // cam_we monitor
  int         we_pulses = 0;
  int         we_long = 0;
  logic [7:0] we_last = 8'h00;
  logic [7:0] we_prev = 8'h00;

  cam_request_controller #(
    .CAM_DEPTH(8), .CAM_WIDTH(8), .IDX_W(3), .MATCH_LAT(MATCH_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_mask(req_mask), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_index(rsp_index), .rsp_err(rsp_err),
    .cam_we(cam_we), .cam_search_word(cam_search_word),
    .cam_dont_care_mask(cam_dont_care_mask), .cam_match(cam_match),
    .full(full), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    raw_match = 8'h00;
    for (int i = 0; i < 8; i++)
      raw_match[i] = (((mem[i] ^ cam_search_word) & ~cam_dont_care_mask) == 8'h00);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) mem[i] <= 8'h00;
      else if (cam_we[i]) mem[i] <= cam_search_word;
    end
    mpipe[0] <= force_en ? force_val : raw_match;
    for (int i = 1; i < MATCH_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign cam_match = mpipe[MATCH_LAT-1];

  always @(negedge clk) begin
    if (cam_we != 8'h00) begin
      we_pulses <= we_pulses + 1;
      we_last   <= cam_we;
      if (we_prev != 8'h00) we_long <= we_long + 1;
    end
    we_prev <= cam_we;
  end

  task automatic send_req(input logic [1:0] op, input logic [7:0] word, input logic [7:0] mask,
                          input logic [2:0] idx, input rsp_t exp, output int at);
    bit rdy;
    rdy = 1'b0;
    at  = -1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_word = word; req_mask = mask; req_index = idx;
    exp_q.push_back(exp);
    for (int n = 0; n < 50; n++) begin
      if (req_ready) begin rdy = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL req_accept_timeout: req_ready stayed 0, required 1");
    end else begin
      @(posedge clk);
      #1 at = cyc;
    end
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output rsp_t got, output int at);
    got = '0;
    at  = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = {rsp_hit, rsp_index, rsp_err};
        at  = cyc;
        break;
      end
    end
    if (at >= 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] word, input logic [7:0] mask,
                        input logic [2:0] idx, input rsp_t exp,
                        output rsp_t got, output rsp_t want, output int lat);
    int acc, rat;
    send_req(op, word, mask, idx, exp, acc);
    get_rsp(got, rat);
    want = exp_q.pop_front();
    lat  = rat - acc;
    checks++;
    if (rat < 0) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0, required 1");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_word = 8'h00; req_mask = 8'h00; req_index = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, cam_we, count, full} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b we=%h count=%0d full=%b, required all 0",
               req_ready, rsp_valid, cam_we, count, full);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_write;
    logic [7:0] words [3];
    rsp_t got, want;
    int lat, p0, l0;
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      p0 = we_pulses; l0 = we_long;
      run_op(OP_WRITE, words[i], 8'hFF, 3'd0, '{hit: 1'b0, index: 3'(i), err: 1'b0}, got, want, lat);
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL write%0d_rsp: got hit/idx/err=%b/%0d/%b required %b/%0d/%b",
                 i, got.hit, got.index, got.err, want.hit, want.index, want.err);
      end
      checks++;
      if (we_pulses - p0 != 1 || we_long != l0 || we_last !== (8'h01 << i)) begin
        failures++;
        $display("FAIL write%0d_we: pulses=%0d long=%0d last=%h required 1 pulse of %h",
                 i, we_pulses - p0, we_long - l0, we_last, 8'h01 << i);
      end
    end
    @(negedge clk);
    checks++;
    if (count !== 4'd3 || full !== 1'b0) begin
      failures++;
      $display("FAIL write_count: count=%0d full=%b required 3/0", count, full);
    end
  endtask

  task automatic test_search;
    rsp_t got, want;
    int lat;
    run_op(OP_SEARCH, 8'hB2, 8'h00, 3'd0, '{hit: 1'b1, index: 3'd1, err: 1'b0}, got, want, lat);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL search_b2: got %b/%0d/%b required %b/%0d/%b",
               got.hit, got.index, got.err, want.hit, want.index, want.err);
    end
    // Accept cycle k ends at the accepting edge; cycle k+MATCH_LAT+2 begins MATCH_LAT+1 edges later.
    checks++;
    if (lat != MATCH_LAT + 1) begin
      failures++;
      $display("FAIL search_latency: edges=%0d required %0d", lat, MATCH_LAT + 1);
    end
  endtask

  task automatic test_invalidate;
    rsp_t got, want;
    int lat;
    run_op(OP_INVAL, 8'h00, 8'h00, 3'd1, '{hit: 1'b0, index: 3'd1, err: 1'b0}, got, want, lat);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL inval_row1: got %b/%0d/%b required %b/%0d/%b",
               got.hit, got.index, got.err, want.hit, want.index, want.err);
    end
    force_en = 1'b1; force_val = 8'h06;
    run_op(OP_SEARCH, 8'hB2, 8'h00, 3'd0, '{hit: 1'b1, index: 3'd2, err: 1'b0}, got, want, lat);
    force_en = 1'b0;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL search_masked_invalid: got %b/%0d/%b required %b/%0d/%b",
               got.hit, got.index, got.err, want.hit, want.index, want.err);
    end
    run_op(OP_INVAL, 8'h00, 8'h00, 3'd1, '{hit: 1'b0, index: 3'd1, err: 1'b1}, got, want, lat);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL inval_again: got %b/%0d/%b required %b/%0d/%b",
               got.hit, got.index, got.err, want.hit, want.index, want.err);
    end
    @(negedge clk);
    checks++;
    if (count !== 4'd2) begin
      failures++;
      $display("FAIL inval_count: count=%0d required 2", count);
    end
  endtask

  task automatic test_full;
    logic [7:0] model_valid;
    logic [2:0] free;
    rsp_t got, want;
    int lat, p0;
    model_valid = 8'b0000_0101;
    while (model_valid != 8'hFF) begin
      free = 3'd0;
      for (int r = 7; r >= 0; r--) if (!model_valid[r]) free = 3'(r);
      model_valid[free] = 1'b1;
      run_op(OP_WRITE, 8'h10 + 8'(free), 8'h00, 3'd0, '{hit: 1'b0, index: free, err: 1'b0}, got, want, lat);
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL fill_row%0d: got %b/%0d/%b required %b/%0d/%b", free,
                 got.hit, got.index, got.err, want.hit, want.index, want.err);
      end
    end
    @(negedge clk);
    checks++;
    if (count !== 4'd8 || full !== 1'b1) begin
      failures++;
      $display("FAIL fill_count: count=%0d full=%b required 8/1", count, full);
    end
    for (int k = 0; k < 2; k++) begin
      p0 = we_pulses;
`ifdef CAM_CTRL_REPLACE_EN
      run_op(OP_WRITE, 8'hE0 + 8'(k), 8'h00, 3'd0, '{hit: 1'b0, index: 3'(k), err: 1'b0}, got, want, lat);
      checks++;
      if (we_pulses - p0 != 1 || we_last !== (8'h01 << k)) begin
        failures++;
        $display("FAIL replace%0d_we: pulses=%0d last=%h required 1 pulse of %h",
                 k, we_pulses - p0, we_last, 8'h01 << k);
      end
`else
      run_op(OP_WRITE, 8'hE0 + 8'(k), 8'h00, 3'd0, '{hit: 1'b0, index: 3'd0, err: 1'b1}, got, want, lat);
      checks++;
      if (we_pulses != p0) begin
        failures++;
        $display("FAIL full_write%0d_we: pulses=%0d required 0", k, we_pulses - p0);
      end
`endif
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL full_write%0d_rsp: got %b/%0d/%b required %b/%0d/%b", k,
                 got.hit, got.index, got.err, want.hit, want.index, want.err);
      end
    end
  endtask

  task automatic test_backpressure;
    rsp_t got, want;
    int acc;
    bit seen;
    seen = 1'b0;
    force_en = 1'b1; force_val = 8'h30;
    rsp_ready = 1'b0;
    send_req(OP_SEARCH, 8'h00, 8'hFF, 3'd0, '{hit: 1'b1, index: 3'd4, err: 1'b0}, acc);
    want = exp_q.pop_front();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    force_en = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_rsp_timeout: rsp_valid stayed 0, required 1");
    end
    for (int c = 0; c < 5; c++) begin
      got = {rsp_hit, rsp_index, rsp_err};
      checks++;
      if (rsp_valid !== 1'b1 || got !== want || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b rsp=%b/%0d/%b ready=%b required 1 %b/%0d/%b 0", c,
                 rsp_valid, got.hit, got.index, got.err, req_ready, want.hit, want.index, want.err);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    int acc, seen;
    seen = 0;
    send_req(OP_SEARCH, 8'hA1, 8'h00, 3'd0, '{hit: 1'b1, index: 3'd0, err: 1'b0}, acc);
    @(negedge clk);          // EXEC
    @(negedge clk);          // WAIT
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_rsp: rsp_valid seen %0d cycles, required 0", seen);
    end
    checks++;
    if (count !== 4'd0 || full !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_state: count=%0d full=%b ready=%b required 0/0/1", count, full, req_ready);
    end
  endtask

  task automatic test_nohit_reserved;
    rsp_t got, want;
    int lat, p0;
    run_op(OP_WRITE, 8'h5A, 8'h00, 3'd0, '{hit: 1'b0, index: 3'd0, err: 1'b0}, got, want, lat);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL rewrite_row0: got %b/%0d/%b required %b/%0d/%b",
               got.hit, got.index, got.err, want.hit, want.index, want.err);
    end
    force_en = 1'b1; force_val = 8'h00;
    run_op(OP_SEARCH, 8'h5A, 8'h00, 3'd0, '{hit: 1'b0, index: 3'd0, err: 1'b0}, got, want, lat);
    force_en = 1'b0;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL search_nohit: got %b/%0d/%b required %b/%0d/%b",
               got.hit, got.index, got.err, want.hit, want.index, want.err);
    end
    p0 = we_pulses;
    run_op(OP_RSVD, 8'h77, 8'h00, 3'd3, '{hit: 1'b0, index: 3'd0, err: 1'b1}, got, want, lat);
    checks++;
    if (got.err !== want.err || got.hit !== want.hit || we_pulses != p0) begin
      failures++;
      $display("FAIL reserved_op: err=%b hit=%b pulses=%0d required 1/0/0",
               got.err, got.hit, we_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_search();
    test_invalidate();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_nohit_reserved();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
